// File: rtl/pure_literal_ctrl.sv
// pure_literal_ctrl: streams clause literals into the pure-literal detector, then scans
// its pure vector and offers each seen pure variable as a signed decision assignment.
module pure_literal_ctrl #(
    parameter int WIDTH = 8,
    parameter int NVARS = 256,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW:0]      num_lits,
    output logic             busy,
    output logic             done,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH:0]   mem_rdata,
    input  logic             mem_active,
    output logic             det_clear,
    output logic [WIDTH:0]   det_lit,
    output logic             det_en,
    output logic             det_inputs_came,
    input  logic [NVARS-1:0] det_pure,
    output logic             assign_valid,
    input  logic             assign_ready,
    output logic [WIDTH:0]   assign_lit,
    output logic [WIDTH:0]   pure_count
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, SCAN, DONE} state_t;
    state_t state_q, state_d;
    logic [AW:0]       n_q;
    logic [AW-1:0]     addr_q;
    logic [1:0]        drain_q;
    logic              rd_q;
    logic              det_en_q;
    logic [WIDTH:0]    det_lit_q;
    logic [WIDTH:0]    pure_count_q;
    logic [WIDTH-1:0]  p_q;
    logic [NVARS-1:0]  seen_q;
    logic [NVARS-1:0]  sgn_q;
    logic [WIDTH-1:0]  v;
    logic              qual;
    logic              last_rd;
    logic              cand;
    logic              adv;
    // Negating the low bits yields |lit| mod 2**WIDTH, so the overflow word maps to 0 and is skipped.
    assign v       = mem_rdata[WIDTH] ? -mem_rdata[WIDTH-1:0] : mem_rdata[WIDTH-1:0];
    assign qual    = rd_q && mem_active && v != '0;
    assign last_rd = {1'b0, addr_q} == n_q - (AW+1)'(1);
    // The detector flags untouched variables as pure, so seen_q masks them out.
    assign cand    = seen_q[p_q] & det_pure[p_q];
    assign adv     = !cand || assign_ready;
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = n_q == '0 ? DRAIN : FETCH;
            FETCH:   if (last_rd) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'd2) state_d = SCAN;
            SCAN:    if (&p_q && adv) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy            = state_q != IDLE;
        done            = state_q == DONE;
        mem_rd_en       = state_q == FETCH;
        mem_addr        = addr_q;
        det_clear       = state_q == CLEAR;
        det_inputs_came = state_q == SCAN || state_q == DONE;
        assign_valid    = state_q == SCAN && cand;
        assign_lit      = !assign_valid ? '0 : sgn_q[p_q] ? -{1'b0, p_q} : {1'b0, p_q};
        det_en          = det_en_q;
        det_lit         = det_lit_q;
        pure_count      = pure_count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q          <= '0;
            addr_q       <= '0;
            drain_q      <= '0;
            rd_q         <= 1'b0;
            det_en_q     <= 1'b0;
            det_lit_q    <= '0;
            pure_count_q <= '0;
            p_q          <= WIDTH'(1);
            seen_q       <= '0;
            sgn_q        <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                n_q          <= num_lits;
                pure_count_q <= '0;
                seen_q       <= '0;
                sgn_q        <= '0;
            end
            addr_q   <= state_q == FETCH ? addr_q + AW'(1) : '0;
            drain_q  <= state_q == DRAIN ? drain_q + 2'd1 : 2'd0;
            rd_q     <= mem_rd_en;
            det_en_q <= qual;
            if (qual) det_lit_q <= mem_rdata;
            if (qual && !seen_q[v]) begin
                seen_q[v] <= 1'b1;
                sgn_q[v]  <= mem_rdata[WIDTH];
            end
            p_q <= state_q == SCAN ? (adv ? p_q + WIDTH'(1) : p_q) : WIDTH'(1);
            if (assign_valid && assign_ready) pure_count_q <= pure_count_q + (WIDTH+1)'(1);
        end
    end
endmodule

// File: tb/tb_pure_literal_ctrl.sv
// tb_pure_literal_ctrl: literal memory and detector models around the sequencer, with a
// scoreboard of expected assignments checked as the consumer accepts them.
module tb_pure_literal_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [10:0]  num_lits = '0;
    logic         busy, done, mem_rd_en, det_clear, det_en, det_inputs_came, assign_valid;
    logic [9:0]   mem_addr;
    logic [8:0]   mem_rdata = '0;
    logic         mem_active = 1'b0;
    logic [8:0]   det_lit, assign_lit, pure_count;
    logic [255:0] det_pure;
    logic         assign_ready = 1'b1;
    logic [8:0]   mem [0:1023];
    bit           act [0:1023];
    bit   [255:0] pos = '0;
    bit   [255:0] neg = '0;
    logic [8:0]   exp_q[$];
    int           checks = 0, failures = 0;
    int           clears, dones, rds, zeros, stall_left = 0, cyc;
    bit           stall_prev = 0;
    logic [8:0]   prev_lit;

    pure_literal_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .num_lits(num_lits), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_active(mem_active),
        .det_clear(det_clear), .det_lit(det_lit), .det_en(det_en), .det_inputs_came(det_inputs_came),
        .det_pure(det_pure), .assign_valid(assign_valid), .assign_ready(assign_ready),
        .assign_lit(assign_lit), .pure_count(pure_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata  <= mem[mem_addr];
            mem_active <= act[mem_addr];
        end
        if (det_clear) begin
            pos <= '0;
            neg <= '0;
        end else if (det_en) begin
            if ($signed(det_lit) < 0) neg[-$signed(det_lit)] <= 1'b1;
            else pos[det_lit] <= 1'b1;
        end
    end
    assign det_pure = ~(pos & neg);

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0 && assign_valid) begin
            assign_ready = 1'b0;
            stall_left--;
        end else assign_ready = 1'b1;
    end

    always @(negedge clk) begin
        if (det_clear) clears++;
        if (done) dones++;
        if (mem_rd_en) rds++;
        if (det_en && det_lit[7:0] == '0) zeros++;
        if (stall_prev) begin
            chk("hold_valid", assign_valid, 1);
            chk("hold_lit", assign_lit, prev_lit);
        end
        if (assign_valid && assign_ready) begin
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("assign_lit", assign_lit, exp_q.pop_front());
        end
        stall_prev = assign_valid && !assign_ready && !reset;
        prev_lit   = assign_lit;
    end

    task automatic put(input int a, input int l, input bit ac);
        mem[a] = 9'(l);
        act[a] = ac;
    endtask

    task automatic do_run(input int n, input int exp_cnt, input bit ghost, output int c);
        clears = 0;
        dones = 0;
        rds = 0;
        zeros = 0;
        num_lits = 11'(n);
        start = 1'b1;
        c = 0;
        while (dones == 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
            num_lits = '0;
            start = ghost && c == 3;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", dones, 1);
        chk("clear_pulses", clears, 1);
        chk("reads", rds, n);
        chk("zero_to_det", zeros, 0);
        chk("busy_after", busy, 0);
        chk("pure_count", pure_count, exp_cnt);
        chk("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) put(i, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", mem_rd_en, 0);
        chk("rst_clear", det_clear, 0);
        chk("rst_det_en", det_en, 0);
        chk("rst_came", det_inputs_came, 0);
        chk("rst_valid", assign_valid, 0);
        chk("rst_count", pure_count, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        put(0, 3, 1); put(1, -5, 1); put(2, 3, 1); put(3, 7, 1); put(4, -5, 1);
        exp_q.push_back(9'(3)); exp_q.push_back(9'(-5)); exp_q.push_back(9'(7));
        do_run(5, 3, 1'b0, cyc);
        put(0, 2, 1); put(1, -2, 1); put(2, 4, 1); put(3, 0, 1);
        exp_q.push_back(9'(4));
        do_run(4, 1, 1'b0, cyc);
        put(0, 1, 1); put(1, -1, 0);
        exp_q.push_back(9'(1));
        do_run(2, 1, 1'b0, cyc);
        put(0, 6, 1); put(1, -9, 1);
        exp_q.push_back(9'(6)); exp_q.push_back(9'(-9));
        stall_left = 5;
        do_run(2, 2, 1'b0, cyc);
        chk("stall_used", stall_left, 0);
        do_run(0, 0, 1'b0, cyc);
        chk("empty_latency", cyc <= 262, 1);
        put(0, 4, 1); put(1, 5, 1);
        num_lits = 11'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_fetch", mem_rd_en, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", assign_valid, 0);
        chk("abort_count", pure_count, 0);
        put(0, -4, 1);
        exp_q.push_back(9'(-4));
        do_run(1, 1, 1'b1, cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
